// File: rtl/data_mem_req_queue.sv
// Data memory request queue: FIFO of core requests feeding a
// single-outstanding req/gnt/rvalid memory port with timeout.
module data_mem_req_queue #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_req_valid_i,
  output logic                    core_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic                    core_we_i,
  input  logic [DATA_WIDTH/8-1:0] core_be_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  output logic                    core_resp_valid_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    core_err_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i
);

  localparam int BW   = DATA_WIDTH / 8;
  localparam int PW   = $clog2(DEPTH);
  localparam int PTRW = PW + 1;
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT_RV, RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BW-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  entry_t          push_entry;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic            full, empty, push, pop;

  state_t          state_q, state_d;
  entry_t          hold_q, hold_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            resp_q, resp_d;
  logic            tmo;

  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = core_req_valid_i && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign tmo   = (cnt_q == CW'(TIMEOUT - 1));

  assign push_entry = '{
    addr:  core_addr_i,
    we:    core_we_i,
    be:    core_be_i,
    wdata: core_wdata_i
  };

  assign core_req_ready_o  = !full;
  assign core_resp_valid_o = resp_q;
  assign core_rdata_o      = rdata_q;
  assign core_err_o        = err_q;

  // The grant masks req/we so memory never sees req while gnt is high
  assign mem_req_o   = (state_q == REQ) && !mem_gnt_i;
  assign mem_we_o    = mem_req_o && hold_q.we;
  assign mem_addr_o  = hold_q.addr;
  assign mem_be_o    = hold_q.be;
  assign mem_wdata_o = hold_q.wdata;

  // FIFO pointer advance
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTRW'(push);
    rd_ptr_d = rd_ptr_q + PTRW'(pop);
  end

  // Next state, timeout count and response capture
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    resp_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          hold_d  = fifo_q[rd_ptr_q[PW-1:0]];
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          cnt_d   = '0;
          state_d = WAIT_RV;
        end else if (tmo) begin
          rdata_d = '0;
          err_d   = 1'b1;
          resp_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_RV: begin
        if (mem_rvalid_i) begin
          rdata_d = hold_q.we ? '0 : mem_rdata_i;
          err_d   = mem_err_i;
          resp_d  = 1'b1;
          state_d = RESP;
        end else if (tmo) begin
          rdata_d = '0;
          err_d   = 1'b1;
          resp_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q[PW-1:0]] <= push_entry;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      hold_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      resp_q   <= resp_d;
    end
  end

endmodule

// File: tb/tb_data_mem_req_queue.sv
// Bench for data_mem_req_queue: vector table plus directed
// sequences for back-pressure, timeouts and mid-flight reset.
module tb_data_mem_req_queue;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic          core_req_valid_i;
  logic          core_req_ready_o;
  logic [AW-1:0] core_addr_i;
  logic          core_we_i;
  logic [BW-1:0] core_be_i;
  logic [DW-1:0] core_wdata_i;
  logic          core_resp_valid_o;
  logic [DW-1:0] core_rdata_o;
  logic          core_err_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_err_i;

  data_mem_req_queue #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(4),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .core_req_valid_i(core_req_valid_i),
    .core_req_ready_o(core_req_ready_o),
    .core_addr_i(core_addr_i),
    .core_we_i(core_we_i),
    .core_be_i(core_be_i),
    .core_wdata_i(core_wdata_i),
    .core_resp_valid_o(core_resp_valid_o),
    .core_rdata_o(core_rdata_o),
    .core_err_o(core_err_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int we_cnt = 0;
  bit gnt_en = 1'b1;
  bit rvalid_en = 1'b1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;
  rsp_t resp_q[$];

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vt[10];

  logic [31:0] mem [64];
  logic [7:0]  p_addr;
  logic        p_we;
  logic [3:0]  p_be;
  logic [31:0] p_wdata;
  logic        pend;

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] init_word(input int w);
    return 32'hB000B1E5 | (32'(w) << 16);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: gnt one cycle after req, rvalid one cycle after gnt
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_gnt_i    <= 1'b0;
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= '0;
      mem_err_i    <= 1'b0;
      pend         <= 1'b0;
      for (int w = 0; w < 64; w++) mem[w] <= init_word(w);
    end else begin
      mem_gnt_i <= gnt_en && mem_req_o;
      if (gnt_en && mem_req_o) begin
        p_addr  <= mem_addr_o;
        p_we    <= mem_we_o;
        p_be    <= mem_be_o;
        p_wdata <= mem_wdata_o;
      end
      mem_rvalid_i <= 1'b0;
      if ((mem_gnt_i || pend) && rvalid_en) begin
        mem_rvalid_i <= 1'b1;
        pend         <= 1'b0;
        mem_err_i    <= (p_addr[7:6] == 2'b11);
        mem_rdata_i  <= mem[p_addr[7:2]];
        if (p_we) mem[p_addr[7:2]] <= merge(mem[p_addr[7:2]], p_be, p_wdata);
      end else if (mem_gnt_i) begin
        pend <= 1'b1;
      end
    end
  end

  logic        trk = 1'b0;
  logic [7:0]  trk_addr;
  logic        prev_resp = 1'b0;

  // Per-cycle protocol monitor and response collector
  always @(negedge clk) begin
    if (!rst_n) begin
      trk = 1'b0;
      prev_resp = 1'b0;
    end else begin
      if (core_resp_valid_o)
        resp_q.push_back('{core_rdata_o, core_err_o, cyc});
      if (mem_we_o) we_cnt++;
      nvec++;
      if (mem_req_o && mem_gnt_i) begin
        nerr++;
        $display("FAIL req_gnt_overlap: req=%b gnt=%b required not both 1",
                 mem_req_o, mem_gnt_i);
      end
      if (trk) begin
        nvec++;
        if (mem_addr_o !== trk_addr) begin
          nerr++;
          $display("FAIL addr_stable: got %h required %h",
                   mem_addr_o, trk_addr);
        end
      end
      if (core_resp_valid_o) begin
        nvec++;
        if (prev_resp) begin
          nerr++;
          $display("FAIL resp_pulse_width: got 2+ cycles required 1");
        end
      end
      if (trk && (mem_rvalid_i || core_resp_valid_o)) begin
        trk = 1'b0;
      end else if (!trk && mem_req_o) begin
        trk = 1'b1;
        trk_addr = mem_addr_o;
      end
      prev_resp = core_resp_valid_o;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic we, input logic [7:0] a,
                      input logic [3:0] be, input logic [31:0] wd,
                      output int pc);
    int k;
    k = 0;
    core_req_valid_i = 1'b1;
    core_we_i        = we;
    core_addr_i      = a;
    core_be_i        = be;
    core_wdata_i     = wd;
    while (!core_req_ready_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      nvec++;
      nerr++;
      $display("FAIL push_stall: got ready=0 for 200 cycles required 1");
    end
    @(posedge clk);
    @(negedge clk);
    pc = cyc;
    core_req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(output rsp_t r);
    int k;
    k = 0;
    while (resp_q.size() == 0 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (resp_q.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL resp_timeout: got no response required one");
      r = '{32'h0, 1'b0, 0};
    end else begin
      r = resp_q.pop_front();
    end
  endtask

  initial begin
    rsp_t r;
    int   pc, pc2;
    logic [31:0] exp_ord [6];

    vt[0] = '{1'b0, 8'h00, 4'hF, 32'h0,        32'hB000B1E5, 1'b0};
    vt[1] = '{1'b1, 8'h04, 4'h3, 32'h12345678, 32'h00000000, 1'b0};
    vt[2] = '{1'b0, 8'h04, 4'hF, 32'h0,        32'hB0015678, 1'b0};
    vt[3] = '{1'b1, 8'h08, 4'hC, 32'hAABBCCDD, 32'h00000000, 1'b0};
    vt[4] = '{1'b0, 8'h08, 4'hF, 32'h0,        32'hAABBB1E5, 1'b0};
    vt[5] = '{1'b0, 8'hC0, 4'hF, 32'h0,        32'hB030B1E5, 1'b1};
    vt[6] = '{1'b1, 8'hF0, 4'hF, 32'hDEADBEEF, 32'h00000000, 1'b1};
    vt[7] = '{1'b0, 8'hF0, 4'hF, 32'h0,        32'hDEADBEEF, 1'b1};
    vt[8] = '{1'b1, 8'h3C, 4'h1, 32'h000000FF, 32'h00000000, 1'b0};
    vt[9] = '{1'b0, 8'h3C, 4'hF, 32'h0,        32'hB00FB1FF, 1'b0};

    exp_ord[0] = 32'hB009B1E5;
    exp_ord[1] = 32'hB004B1E5;
    exp_ord[2] = 32'hB005B1E5;
    exp_ord[3] = 32'hB006B1E5;
    exp_ord[4] = 32'hB007B1E5;
    exp_ord[5] = 32'hB008B1E5;

    rst_n = 1'b1;
    core_req_valid_i = 1'b0;
    core_addr_i  = '0;
    core_we_i    = 1'b0;
    core_be_i    = '0;
    core_wdata_i = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(core_req_ready_o), 32'd1);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_resp", 32'(core_resp_valid_o), 32'd0);
    chk("rst_rdata", core_rdata_o, 32'h0);
    chk("rst_err", 32'(core_err_o), 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      resp_q.delete();
      we_cnt = 0;
      push(vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, pc);
      wait_resp(r);
      chk($sformatf("v%0d_rdata", i), r.rdata, vt[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(r.err), 32'(vt[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(r.cyc - pc), 32'd4);
      chk($sformatf("v%0d_we_cycles", i), 32'(we_cnt), 32'(vt[i].we));
      repeat (2) @(negedge clk);
    end

    resp_q.delete();
    gnt_en = 1'b0;
    push(1'b0, 8'h24, 4'hF, 32'h0, pc);
    for (int i = 0; i < 4; i++) push(1'b0, 8'(8'h10 + 4 * i), 4'hF, 32'h0, pc);
    #1;
    chk("full_ready_low", 32'(core_req_ready_o), 32'd0);
    gnt_en = 1'b1;
    push(1'b0, 8'h20, 4'hF, 32'h0, pc);
    for (int i = 0; i < 6; i++) begin
      wait_resp(r);
      chk($sformatf("order%0d_rdata", i), r.rdata, exp_ord[i]);
      chk($sformatf("order%0d_err", i), 32'(r.err), 32'd0);
    end
    repeat (2) @(negedge clk);

    resp_q.delete();
    rvalid_en = 1'b0;
    push(1'b0, 8'h30, 4'hF, 32'h0, pc);
    wait_resp(r);
    chk("rv_tmo_err", 32'(r.err), 32'd1);
    chk("rv_tmo_rdata", r.rdata, 32'h0);
    chk("rv_tmo_latency", 32'(r.cyc - pc), 32'(TO + 3));
    rvalid_en = 1'b1;
    repeat (4) @(negedge clk);

    resp_q.delete();
    gnt_en = 1'b0;
    push(1'b0, 8'h28, 4'hF, 32'h0, pc);
    push(1'b0, 8'h2C, 4'hF, 32'h0, pc2);
    wait_resp(r);
    chk("gnt_tmo_err", 32'(r.err), 32'd1);
    chk("gnt_tmo_rdata", r.rdata, 32'h0);
    chk("gnt_tmo_latency", 32'(r.cyc - pc), 32'(TO + 1));
    gnt_en = 1'b1;
    wait_resp(r);
    chk("after_tmo_rdata", r.rdata, 32'hB00BB1E5);
    chk("after_tmo_err", 32'(r.err), 32'd0);
    repeat (2) @(negedge clk);

    rvalid_en = 1'b0;
    push(1'b0, 8'h34, 4'hF, 32'h0, pc);
    push(1'b0, 8'h38, 4'hF, 32'h0, pc);
    push(1'b0, 8'h3C, 4'hF, 32'h0, pc);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(core_req_ready_o), 32'd1);
    chk("mid_rst_req", 32'(mem_req_o), 32'd0);
    chk("mid_rst_we", 32'(mem_we_o), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr_o), 32'd0);
    chk("mid_rst_be", 32'(mem_be_o), 32'd0);
    chk("mid_rst_wdata", mem_wdata_o, 32'h0);
    chk("mid_rst_resp", 32'(core_resp_valid_o), 32'd0);
    chk("mid_rst_rdata", core_rdata_o, 32'h0);
    chk("mid_rst_err", 32'(core_err_o), 32'd0);
    resp_q.delete();
    rvalid_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    chk("post_rst_no_resp", 32'(resp_q.size()), 32'd0);
    chk("post_rst_ready", 32'(core_req_ready_o), 32'd1);
    chk("post_rst_req", 32'(mem_req_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
